// File: rtl/const_seq_src.sv
// Burst data source: idles on CONST_VAL, then streams len items (CONST/INCR/WALK) over valid/ready.
// Optional abort input is enabled by defining CONST_SEQ_SRC_ABORT_EN.
module const_seq_src #(
  parameter int WIDTH     = 8,
  parameter int CONST_VAL = 1,
  parameter int LW        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [LW-1:0]    len,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
`ifdef CONST_SEQ_SRC_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: an item moves when out_val && out_rdy on a rising edge; out_data
  // is held while out_val is high and out_rdy is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] IDLE_DATA = WIDTH'(CONST_VAL);

  state_t           state;
  logic [1:0]       mode_q;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_next;
  logic             xfer;
  logic             last;
  logic             abort_hit;

`ifdef CONST_SEQ_SRC_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign xfer      = out_val && out_rdy;
  assign last      = xfer && (count == LW'(1));
  assign out_data  = data;
  assign dbg_state = state;

  always_comb begin
    data_next = data;
    case (mode_q)
      2'b01:   data_next = data + WIDTH'(1);
      2'b10:   data_next = {data[WIDTH-2:0], data[WIDTH-1]};
      default: data_next = data;
    endcase
  end

  // data doubles as the output register, so it is parked on CONST_VAL outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= 2'b00;
      count   <= '0;
      data    <= IDLE_DATA;
      out_val <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              data    <= seed;
              count   <= len;
              out_val <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            count <= count - LW'(1);
            data  <= data_next;
          end
          if (last || abort_hit) begin
            state   <= DONE;
            data    <= IDLE_DATA;
            out_val <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          data    <= IDLE_DATA;
          out_val <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_seq_src.sv
// Bench for const_seq_src: expected items are queued when a burst starts and
// popped as the source transfers them.
module tb_const_seq_src;

  localparam int WIDTH = 8;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [LW-1:0]    len;
  logic             out_val;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;
`ifdef CONST_SEQ_SRC_ABORT_EN
  logic             abort = 1'b0;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  const_seq_src #(.WIDTH(WIDTH), .CONST_VAL(1), .LW(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .len       (len),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
`ifdef CONST_SEQ_SRC_ABORT_EN
    .abort     (abort),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_next(input logic [1:0] m, input logic [WIDTH-1:0] d);
    case (m)
      2'b01:   return d + 8'd1;
      2'b10:   return {d[WIDTH-2:0], d[WIDTH-1]};
      default: return d;
    endcase
  endfunction

  task automatic push_items(input logic [1:0] m, input logic [WIDTH-1:0] s, input int l);
    logic [WIDTH-1:0] d;
    d = s;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(d);
      d = model_next(m, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {done, out_val, busy, out_data}, {3'b000, 8'h01});
  endtask

  // scoreboard: compare on transfers, and against the head item while stalled
  always @(negedge clk) begin
    if (!reset && out_val) begin
      if (exp_q.size() == 0)
        check("spurious_item", 32'(exp_q.size()), 32'd1);
      else if (out_rdy)
        check("xfer_data", out_data, exp_q.pop_front());
      else
        check("stall_data", out_data, exp_q[0]);
    end
  end

  // driver: start a burst, stall the first 'stall' RUN cycles, wait for done
  task automatic run_burst(input logic [1:0] m, input logic [WIDTH-1:0] s, input int l,
                           input int stall, input bit hold_start);
    int cyc;
    push_items(m, s, l);
    mode    = m;
    seed    = s;
    len     = LW'(l);
    start   = 1'b1;
    out_rdy = (stall == 0);
    tick();
    if (!hold_start) start = 1'b0;
    seed = s ^ 8'h5A;
    mode = m + 2'd1;
    cyc  = 0;
    if (l != 0) check("first_valid", {busy, out_val}, 2'b11);
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      out_rdy = (cyc >= stall);
    end
    start = 1'b0;
    check("done_latency", cyc, l + stall);
    check("items_left", 32'(exp_q.size()), 0);
    exp_q.delete();
    tick();
    check_idle("after_done");
    check("idle_state", dbg_state, 2'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b1;
    mode    = 2'b01;
    seed    = 8'h33;
    len     = 4'd3;
    out_rdy = 1'b1;
    tick();
    tick();
    // reset wins over a simultaneous start
    check_idle("reset_over_start");
    check("reset_state", dbg_state, 2'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_idle("idle_cycle1");
    tick();
    check_idle("idle_cycle2");

    run_burst(2'b01, 8'hFE, 3, 0, 1'b0);   // INCR wraps FF -> 00
    run_burst(2'b10, 8'h80, 2, 2, 1'b1);   // WALK with stalls, start held high
    run_burst(2'b00, 8'h77, 0, 0, 1'b0);   // zero length
    run_burst(2'b11, 8'hA5, 4, 1, 1'b0);   // mode 11 acts as CONST

    // reset in the middle of an INCR burst after two transfers
    push_items(2'b01, 8'h10, 5);
    mode = 2'b01; seed = 8'h10; len = 4'd5; start = 1'b1; out_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_rdy = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset_idle");
    check("mid_reset_state", dbg_state, 2'd0);
    check("mid_reset_left", 32'(exp_q.size()), 3);
    exp_q.delete();
    run_burst(2'b01, 8'h20, 3, 0, 1'b0);

`ifdef CONST_SEQ_SRC_ABORT_EN
    // abort in the second RUN cycle: that cycle's transfer still happens
    push_items(2'b01, 8'h40, 2);
    mode = 2'b01; seed = 8'h40; len = 4'd8; start = 1'b1; out_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", done, 1'b1);
    check("abort_items_left", 32'(exp_q.size()), 0);
    exp_q.delete();
    tick();
    check_idle("abort_idle");
`endif

    for (int i = 0; i < 6; i++) begin
      int l;
      l = $urandom_range(0, 15);
      run_burst(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), l,
                (l != 0) ? $urandom_range(0, 3) : 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/const_seq_src.md
CONST_SEQ_SRC -- requirements
Module: const_seq_src

Interface
REQ-001 Parameters, one per line:
- WIDTH, 8, data width (>=2).
- CONST_VAL, 1, value driven on out_data while idle.
- LW, 4, width of burst-length field.
REQ-002 Ports, one per line:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin burst; sampled only in IDLE.
- mode  input  2  00 CONST, 01 INCR, 10 WALK, 11 treated as CONST.
- seed  input  WIDTH  first data value of burst.
- len  input  LW  number of items in burst (0 = none).
- out_val  output  1  out_data valid.
- out_rdy  input  1  consumer ready.
- out_data  output  WIDTH  current item.
- busy  output  1  high in RUN.
- done  output  1  one-cycle burst-complete pulse.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 In IDLE: out_val=0, busy=0, done=0, out_data=CONST_VAL.
REQ-006 IDLE with start=1 SHALL latch mode, seed and len, then go to DONE if len==0, else RUN with data register=seed and count=len.
REQ-007 start outside IDLE SHALL be ignored.
REQ-008 In RUN: out_val=1, busy=1, out_data=data register.
REQ-009 A transfer SHALL occur in any RUN cycle with out_val&&out_rdy, and never otherwise.
REQ-010 On transfer: count decrements; data updates to unchanged (CONST), data+1 modulo 2^WIDTH (INCR), or rotate-left by 1, MSB into LSB (WALK).
REQ-011 A transfer with count==1 SHALL move the FSM to DONE next cycle.
REQ-012 While out_val=1 and out_rdy=0, out_data SHALL stay stable.
REQ-013 In DONE: done=1, out_val=0, busy=0, out_data=CONST_VAL; the FSM SHALL return to IDLE after exactly one cycle.
REQ-014 Latency: first item valid the cycle after start; N items with out_rdy held high take N cycles; done follows the last transfer by one cycle.
REQ-015 A zero-length burst SHALL pulse done the cycle after start with no transfers.
REQ-016 An INCR burst SHALL wrap 0xFF to 0x00 (WIDTH=8) without error.

Reset
REQ-017 Reset SHALL force IDLE with count=0, data=CONST_VAL, out_val=0, busy=0, done=0, both at power-up and in the middle of a burst.
REQ-018 Reset SHALL take precedence over start, transfer and abort in the same cycle.

Configuration
REQ-019 Macro CONST_SEQ_SRC_ABORT_EN SHALL control an abort feature.
REQ-020 With CONST_SEQ_SRC_ABORT_EN defined, a 1-bit input abort SHALL exist.
- abort=1 in RUN: next state DONE, no further transfers.
- A transfer in the same cycle still counts.
- abort is ignored outside RUN.
REQ-021 Without the macro, no abort port SHALL exist and bursts end only per REQ-011 or reset.

Verification
REQ-022 Scenarios (WIDTH=8, CONST_VAL=1, LW=4):
- Reset, no start -> out_data=0x01, out_val=0 for 2 cycles.
- start, mode=01, seed=0xFE, len=3, out_rdy=1 -> out_data 0xFE, 0xFF, 0x00, then done=1 for one cycle.
- start, mode=10, seed=0x80, len=2, out_rdy low for 2 RUN cycles -> 0x80 held stable, then 0x80, 0x01, done.
- start, mode=00, len=0 -> no out_val, done=1 the cycle after start, then back to IDLE.
- reset asserted mid-burst (INCR, len=5, after 2 transfers) -> next cycle IDLE, out_data=0x01; a new start then behaves normally.
- CONST_SEQ_SRC_ABORT_EN: abort in the 2nd RUN cycle of a len=8 burst -> exactly 2 transfers, then done.
